// File: rtl/tile_pkg.sv
// Shared constants, types and the fixed colour palette for the tile pixel pipe.
package tile_pkg;

   localparam int TILE_PX         = 40;
   localparam int MAP_W           = 16;
   localparam int MAP_H           = 12;
   localparam int TEX_AW          = 15;
   localparam int TEXELS_PER_TILE = TILE_PX * TILE_PX;

   typedef logic [3:0] tile_id_t;
   typedef logic [3:0] pal_idx_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   localparam rgb_t SKY_RGB   = 24'h87CEEB;
   localparam rgb_t WHITE_RGB = 24'hFFFFFF;
   localparam rgb_t BLACK_RGB = 24'h000000;

   // Entries 6..15 are unused block types and show up as magenta on purpose.
   localparam rgb_t PALETTE [16] = '{
      24'h000000, 24'h7F7F7F, 24'h8B5A2B, 24'h3CB043,
      24'hA0522D, 24'h228B22, 24'hFF00FF, 24'hFF00FF,
      24'hFF00FF, 24'hFF00FF, 24'hFF00FF, 24'hFF00FF,
      24'hFF00FF, 24'hFF00FF, 24'hFF00FF, 24'hFF00FF
   };

endpackage

// File: rtl/tile_pixel_pipe_if.sv
// Read bus between the pixel pipe and the world-map RAM / texture ROM.
// Both memories return data exactly one clock after the address.
interface tile_pixel_pipe_if;
   import tile_pkg::*;

   logic [7:0]        map_addr;
   logic [3:0]        map_data;
   logic [TEX_AW-1:0] tex_addr;
   logic [3:0]        tex_data;

   modport master (
      output map_addr,
      output tex_addr,
      input  map_data,
      input  tex_data
   );

   modport slave (
      input  map_addr,
      input  tex_addr,
      output map_data,
      output tex_data
   );

endinterface

// File: rtl/tile_palette.sv
// Combinational palette lookup: palette index to 24-bit colour.
module tile_palette
   import tile_pkg::*;
(
   input  pal_idx_t pal_idx,
   output rgb_t     rgb
);

   assign rgb = PALETTE[pal_idx];

endmodule

// File: rtl/tile_pixel_pipe.sv
// Four-stage pixel shading pipe: map fetch, texel fetch, palette and cursor
// border, registered RGB. Sync/blank sidebands are delayed to stay aligned.
module tile_pixel_pipe
   import tile_pkg::*;
(
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic [3:0]          x,
   input  logic [3:0]          y,
   input  logic [5:0]          relx,
   input  logic [5:0]          rely,
   input  logic                hs_in,
   input  logic                vs_in,
   input  logic                blank_n_in,
   input  logic [3:0]          cursor_x,
   input  logic [3:0]          cursor_y,
   input  logic                cursor_en,
   tile_pixel_pipe_if.master   mem,
   output logic [7:0]          VGA_R,
   output logic [7:0]          VGA_G,
   output logic [7:0]          VGA_B,
   output logic                VGA_HS,
   output logic                VGA_VS,
   output logic                VGA_BLANK_N
);

   localparam logic [5:0] REL_LAST = 6'(TILE_PX - 1);

   // Stage 1 registers
   logic [3:0] x_p1, y_p1;
   logic [5:0] relx_p1, rely_p1;
   logic       hs_p1, vs_p1, blank_p1, hit_p1, vld_p1;

   // Stage 2 registers (tile id itself is the map RAM output register)
   logic [5:0] relx_p2, rely_p2;
   logic       hs_p2, vs_p2, blank_p2, hit_p2, vld_p2;
   tile_id_t   tile_p2;

   // Stage 3 registers (palette index itself is the texture ROM output register)
   tile_id_t   tile_p3;
   pal_idx_t   pal_p3;
   logic       hs_p3, vs_p3, blank_p3, hit_p3, border_p3;

   // Stage 4 registers
   rgb_t       rgb_p4;
   logic       hs_p4, vs_p4, blank_p4;

   rgb_t       pal_rgb;
   rgb_t       rgb_next;
   logic [TEX_AW-1:0] tile_w, rely_w, relx_w;

   // ---------------- Stage 1: sample inputs and cursor hit ----------------
   // Register the incoming pixel and decide whether it lies on the cursor tile.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         x_p1     <= '0;
         y_p1     <= '0;
         relx_p1  <= '0;
         rely_p1  <= '0;
         hs_p1    <= 1'b1;
         vs_p1    <= 1'b1;
         blank_p1 <= 1'b0;
         hit_p1   <= 1'b0;
         vld_p1   <= 1'b0;
      end else begin
         x_p1     <= x;
         y_p1     <= y;
         relx_p1  <= relx;
         rely_p1  <= rely;
         hs_p1    <= hs_in;
         vs_p1    <= vs_in;
         blank_p1 <= blank_n_in;
         hit_p1   <= cursor_en && (x == cursor_x) && (y == cursor_y);
         vld_p1   <= 1'b1;
      end
   end

   // Map rows are 16 tiles wide, so row*16+col is a plain concatenation.
   assign mem.map_addr = {y_p1, x_p1};

   // ---------------- Stage 2: tile id arrives, texel address ----------------
   // Forward the in-tile offset and sidebands while the map RAM returns the tile id.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         relx_p2  <= '0;
         rely_p2  <= '0;
         hs_p2    <= 1'b1;
         vs_p2    <= 1'b1;
         blank_p2 <= 1'b0;
         hit_p2   <= 1'b0;
         vld_p2   <= 1'b0;
      end else begin
         relx_p2  <= relx_p1;
         rely_p2  <= rely_p1;
         hs_p2    <= hs_p1;
         vs_p2    <= vs_p1;
         blank_p2 <= blank_p1;
         hit_p2   <= hit_p1;
         vld_p2   <= vld_p1;
      end
   end

   // Masking keeps the texture address at zero until a real pixel reaches stage 2.
   assign tile_p2 = vld_p2 ? mem.map_data : '0;

   assign tile_w = TEX_AW'(tile_p2);
   assign rely_w = TEX_AW'(rely_p2);
   assign relx_w = TEX_AW'(relx_p2);

   // tile*1600 + rely*40 + relx with shift-adds; the largest in-range result is 25599.
   assign mem.tex_addr = (tile_w << 10) + (tile_w << 9) + (tile_w << 6)
                       + (rely_w << 5) + (rely_w << 3) + relx_w;

   // ---------------- Stage 3: texel arrives, border flag ----------------
   // Forward tile id and sidebands, and flag pixels on the outer ring of the tile.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         tile_p3   <= '0;
         hs_p3     <= 1'b1;
         vs_p3     <= 1'b1;
         blank_p3  <= 1'b0;
         hit_p3    <= 1'b0;
         border_p3 <= 1'b0;
      end else begin
         tile_p3   <= tile_p2;
         hs_p3     <= hs_p2;
         vs_p3     <= vs_p2;
         blank_p3  <= blank_p2;
         hit_p3    <= hit_p2;
         border_p3 <= (relx_p2 == '0) || (relx_p2 == REL_LAST) ||
                      (rely_p2 == '0) || (rely_p2 == REL_LAST);
      end
   end

   assign pal_p3 = mem.tex_data;

   tile_palette u_palette (
      .pal_idx (pal_p3),
      .rgb     (pal_rgb)
   );

   // Pick the pixel colour: blanking, then cursor border, then sky, then texture.
   always_comb begin
      rgb_next = BLACK_RGB;
      if (!blank_p3) begin
         rgb_next = BLACK_RGB;
      end else if (hit_p3 && border_p3) begin
         rgb_next = WHITE_RGB;
      end else if (tile_p3 == '0) begin
         rgb_next = SKY_RGB;
      end else begin
         rgb_next = pal_rgb;
      end
   end

   // ---------------- Stage 4: registered outputs ----------------
   // Register colour and the matching sidebands.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rgb_p4   <= BLACK_RGB;
         hs_p4    <= 1'b1;
         vs_p4    <= 1'b1;
         blank_p4 <= 1'b0;
      end else begin
         rgb_p4   <= rgb_next;
         hs_p4    <= hs_p3;
         vs_p4    <= vs_p3;
         blank_p4 <= blank_p3;
      end
   end

   assign VGA_R       = rgb_p4.r;
   assign VGA_G       = rgb_p4.g;
   assign VGA_B       = rgb_p4.b;
   assign VGA_HS      = hs_p4;
   assign VGA_VS      = vs_p4;
   assign VGA_BLANK_N = blank_p4;

endmodule

// File: tb/tb_tile_pixel_pipe.sv
// Bench for tile_pixel_pipe: directed cases plus a random stream against a
// reference model built from the tile/texture addressing and colour rules.
module tb_tile_pixel_pipe;

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic [3:0] x, y, cursor_x, cursor_y;
   logic [5:0] relx, rely;
   logic       hs_in, vs_in, blank_n_in, cursor_en;
   logic [7:0] VGA_R, VGA_G, VGA_B;
   logic       VGA_HS, VGA_VS, VGA_BLANK_N;

   always #5 Clk = ~Clk;

   tile_pixel_pipe_if mif ();

   tile_pixel_pipe dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .x           (x),
      .y           (y),
      .relx        (relx),
      .rely        (rely),
      .hs_in       (hs_in),
      .vs_in       (vs_in),
      .blank_n_in  (blank_n_in),
      .cursor_x    (cursor_x),
      .cursor_y    (cursor_y),
      .cursor_en   (cursor_en),
      .mem         (mif),
      .VGA_R       (VGA_R),
      .VGA_G       (VGA_G),
      .VGA_B       (VGA_B),
      .VGA_HS      (VGA_HS),
      .VGA_VS      (VGA_VS),
      .VGA_BLANK_N (VGA_BLANK_N)
   );

   // Memory models: one clock of read latency each.
   logic [3:0] map_mem [256];
   logic [3:0] tex_mem [32768];

   always @(posedge Clk) begin
      mif.map_data <= map_mem[mif.map_addr];
      mif.tex_data <= tex_mem[mif.tex_addr];
   end

   typedef struct {
      logic [7:0]  ma;
      logic [14:0] ta;
      logic [23:0] rgb;
      logic        hs;
      logic        vs;
      logic        bl;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [23:0] pal_ref(input int i);
      case (i)
         0:       return 24'h000000;
         1:       return 24'h7F7F7F;
         2:       return 24'h8B5A2B;
         3:       return 24'h3CB043;
         4:       return 24'hA0522D;
         5:       return 24'h228B22;
         default: return 24'hFF00FF;
      endcase
   endfunction

   function automatic exp_t reset_rec();
      exp_t e;
      e.ma = 8'd0; e.ta = 15'd0; e.rgb = 24'h0;
      e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b0;
      return e;
   endfunction

   // Expected results for one pixel, from tile/texel arithmetic and the colour rules.
   function automatic exp_t model(input int px, input int py, input int rx, input int ry,
                                  input logic h, input logic v, input logic b);
      exp_t e;
      int   maddr, tile, taddr;
      bit   on_border, hit;
      maddr = py * 16 + px;
      tile  = int'(map_mem[maddr]);
      taddr = tile * 1600 + ry * 40 + rx;
      on_border = (rx == 0) || (rx == 39) || (ry == 0) || (ry == 39);
      hit   = cursor_en && (px == int'(cursor_x)) && (py == int'(cursor_y));
      e.ma  = 8'(maddr);
      e.ta  = 15'(taddr);
      e.hs  = h; e.vs = v; e.bl = b;
      if (!b)                  e.rgb = 24'h000000;
      else if (hit && on_border) e.rgb = 24'hFFFFFF;
      else if (tile == 0)      e.rgb = 24'h87CEEB;
      else                     e.rgb = pal_ref(int'(tex_mem[taddr]));
      return e;
   endfunction

   task automatic check_reset_vals(input string tag);
      chk({tag, "_rgb"},  {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
      chk({tag, "_hs"},   {31'h0, VGA_HS}, 32'h1);
      chk({tag, "_vs"},   {31'h0, VGA_VS}, 32'h1);
      chk({tag, "_bl"},   {31'h0, VGA_BLANK_N}, 32'h0);
      chk({tag, "_ma"},   {24'h0, mif.map_addr}, 32'h0);
      chk({tag, "_ta"},   {17'h0, mif.tex_addr}, 32'h0);
   endtask

   // Called on a falling edge: check the pipe against history, then present a new pixel.
   task automatic step(input int px, input int py, input int rx, input int ry,
                       input logic h, input logic v, input logic b);
      chk("rgb",      {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, q[0].rgb});
      chk("hs",       {31'h0, VGA_HS},      {31'h0, q[0].hs});
      chk("vs",       {31'h0, VGA_VS},      {31'h0, q[0].vs});
      chk("blank",    {31'h0, VGA_BLANK_N}, {31'h0, q[0].bl});
      chk("map_addr", {24'h0, mif.map_addr}, {24'h0, q[3].ma});
      chk("tex_addr", {17'h0, mif.tex_addr}, {17'h0, q[2].ta});
      x = 4'(px); y = 4'(py); relx = 6'(rx); rely = 6'(ry);
      hs_in = h; vs_in = v; blank_n_in = b;
      q.push_back(model(px, py, rx, ry, h, v, b));
      q.delete(0);
      @(negedge Clk);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic restart();
      Reset_n = 1'b1;
      q.delete();
      repeat (4) q.push_back(reset_rec());
   endtask

   task automatic random_pixel();
      int px, py, rx, ry;
      px = $urandom_range(0, 15);
      py = $urandom_range(0, 15);
      rx = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 39) : $urandom_range(0, 63);
      ry = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 39) : $urandom_range(0, 63);
      cursor_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
         cursor_x = 4'(px); cursor_y = 4'(py);
      end else begin
         cursor_x = 4'($urandom_range(0, 15)); cursor_y = 4'($urandom_range(0, 15));
      end
      step(px, py, rx, ry, 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 4) != 0));
   endtask

   initial begin
      for (int i = 0; i < 256; i++)
         map_mem[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      for (int i = 0; i < 32768; i++)
         tex_mem[i] = 4'($urandom_range(0, 15));

      Reset_n = 1'b0;
      x = '0; y = '0; relx = '0; rely = '0;
      hs_in = 1'b1; vs_in = 1'b1; blank_n_in = 1'b0;
      cursor_x = '0; cursor_y = '0; cursor_en = 1'b0;

      // Reset state
      repeat (3) @(negedge Clk);
      check_reset_vals("por");
      restart();

      // Basic fetch: tile 2 at (3,2), offset (5,7) -> map 35, tex 3485, dirt colour
      map_mem[35]   = 4'd2;
      tex_mem[3485] = 4'd2;
      step(3, 2, 5, 7, 1'b1, 1'b1, 1'b1);
      repeat (4) idle();

      // Air tile shows sky regardless of texel
      map_mem[97]  = 4'd0;
      tex_mem[410] = 4'd5;
      step(1, 6, 10, 10, 1'b1, 1'b1, 1'b1);

      // Cursor border on tile (4,4): relx=0 is border, relx=20 is interior
      cursor_en = 1'b1; cursor_x = 4'd4; cursor_y = 4'd4;
      map_mem[68]   = 4'd1;
      tex_mem[2280] = 4'd1;
      tex_mem[2300] = 4'd1;
      step(4, 4, 0, 17, 1'b1, 1'b1, 1'b1);
      step(4, 4, 20, 17, 1'b1, 1'b1, 1'b1);

      // Blanked pixel on a valid tile, then a 3-clock hsync pulse
      step(4, 4, 0, 17, 1'b1, 1'b1, 1'b0);
      cursor_en = 1'b0;
      step(4, 4, 20, 17, 1'b0, 1'b1, 1'b1);
      step(4, 4, 21, 17, 1'b0, 1'b1, 1'b1);
      step(4, 4, 22, 17, 1'b0, 1'b1, 1'b1);
      step(4, 4, 23, 17, 1'b1, 1'b0, 1'b1);

      // Address corner: tile 15 at (15,11), offset (39,39), debug palette entry
      map_mem[191]   = 4'd15;
      tex_mem[25599] = 4'd9;
      step(15, 11, 39, 39, 1'b1, 1'b1, 1'b1);
      repeat (4) idle();

      // Random stream with an asynchronous reset in the middle
      repeat (50) random_pixel();
      @(posedge Clk);
      #2 Reset_n = 1'b0;
      #1 check_reset_vals("midrst_now");
      @(negedge Clk);
      check_reset_vals("midrst_c1");
      @(negedge Clk);
      check_reset_vals("midrst_c2");
      restart();
      repeat (50) random_pixel();
      repeat (4) idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
